// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment scan driver.
// Segment bit order in every glyph: bit 0 = a, 1 = b, 2 = c, 3 = d,
// 4 = e, 5 = f, 6 = g. All glyphs are active-high; pin polarity is
// applied at the output registers of the top.
package seg7_pkg;

  localparam int SEG_BITS = 7;

  localparam logic [SEG_BITS-1:0] GLYPH_BLANK = 7'b0000000;

  // Index = 4-bit digit code. Element [15] is written first.
  localparam logic [15:0][SEG_BITS-1:0] GLYPHS = {
    7'b1110001,  // F
    7'b1111001,  // E
    7'b1011110,  // d
    7'b0111001,  // C
    7'b1111100,  // b
    7'b1110111,  // A
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: bundles the data/control inputs and the display pin
// outputs of seg7_scan_driver.
//   en, value, dp_in, load, lz_blank : from the datapath (master) to driver
//   seg, dp, an, frame_done          : from the driver (slave) to the board
interface seg7_scan_driver_if
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    lz_blank;
  logic [SEG_BITS-1:0]     seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output en, value, dp_in, load, lz_blank,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  en, value, dp_in, load, lz_blank,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: combinational 4-bit digit code to active-high glyph.
//   code  in  4  digit code
//   glyph out 7  segments a..g (bit 0 = a)
// With HEX_MODE = 0 the codes 10..15 render blank.
module seg7_decode
  import seg7_pkg::*;
#(
  parameter int HEX_MODE = 1
) (
  input  logic [3:0]          code,
  output logic [SEG_BITS-1:0] glyph
);

  always_comb begin
    glyph = GLYPHS[code];
    if ((HEX_MODE == 0) && (code > 4'd9)) begin
      glyph = GLYPH_BLANK;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed seven-segment scan driver.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.en        scan enable (low freezes scan, anodes off)
//   bus.value     packed digit codes, digit 0 in bits [3:0]
//   bus.dp_in     per-digit decimal points
//   bus.load      capture value/dp_in into the pending shadow
//   bus.lz_blank  suppress leading zeros
//   bus.seg/dp/an registered pin outputs (polarity applied)
//   bus.frame_done one-cycle pulse when the scan wraps to digit 0
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYC      = 500,
  parameter int HEX_MODE       = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0]         CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [SEG_BITS-1:0]   SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic                  DP_OFF   = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [VW-1:0]         disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic [SEG_BITS-1:0]   seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  logic                  slot_end, wrap;
  logic [3:0]            codes [NUM_DIGITS];
  logic [3:0]            cur_code;
  logic [SEG_BITS-1:0]   cur_glyph, seg_act;
  logic                  dp_act, blank;
  logic [NUM_DIGITS-1:0] an_act;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  lz_run;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_codes
    assign codes[gi] = disp_val_q[4*gi +: 4];
  end

  // Leading-zero mask, scanned from the most significant digit down.
  // A digit blanks while every digit above it was blank and dp-free and
  // its own code is zero; digit 0 is never masked.
  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (lz_run && (codes[i] == 4'd0)) begin
        lz_mask[i] = 1'b1;
      end
      lz_run = lz_mask[i] && !disp_dp_q[i];
    end
  end

  assign cur_code = codes[idx_q];

  seg7_decode #(.HEX_MODE(HEX_MODE)) u_decode (
    .code  (cur_code),
    .glyph (cur_glyph)
  );

  // Scan sequencing and shadow-register update.
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;

    slot_end = bus.en && (cnt_q == CNT_LAST);
    wrap     = slot_end && (idx_q == IDX_LAST);

    if (bus.en) begin
      cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    end
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    if (wrap) begin
      // A load coinciding with the wrap bypasses the shadow so the new
      // value is shown from this frame's digit-0 slot onward.
      if (bus.load) begin
        disp_val_d = bus.value;
        disp_dp_d  = bus.dp_in;
      end else if (pend_valid_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
      pend_valid_d = 1'b0;
    end else if (bus.load) begin
      pend_val_d   = bus.value;
      pend_dp_d    = bus.dp_in;
      pend_valid_d = 1'b1;
    end
  end

  // Output stage: glyph, blanking, dead time and pin polarity.
  always_comb begin
    blank   = bus.lz_blank && lz_mask[idx_q];
    seg_act = blank ? GLYPH_BLANK : cur_glyph;
    dp_act  = blank ? 1'b0 : disp_dp_q[idx_q];
    an_act  = '0;
    if (bus.en && (int'(cnt_q) >= BLANK_CYC)) begin
      an_act = NUM_DIGITS'(1) << idx_q;
    end
    seg_d        = (SEG_ACTIVE_LOW != 0) ? ~seg_act : seg_act;
    dp_d         = (SEG_ACTIVE_LOW != 0) ? ~dp_act : dp_act;
    an_d         = (AN_ACTIVE_LOW != 0) ? ~an_act : an_act;
    frame_done_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int R  = 4;
  localparam int BL = 1;
  localparam int FR = N * R;

  typedef struct packed {
    logic [6:0] seg_a;
    logic       dp_a;
    logic [3:0] an_a;
    logic       fd;
    logic [6:0] seg_b;
    logic       dp_b;
    logic [3:0] an_b;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus_a ();
  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus_b ();

  // Instance A: hex glyphs, active-high segments. Instance B: decimal only,
  // active-low segments. Both have active-low anodes and share stimulus.
  seg7_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYC(BL),
    .HEX_MODE(1), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

  seg7_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYC(BL),
    .HEX_MODE(0), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  always #5 clk = ~clk;

  logic [6:0] gly [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: scan position counted in enabled cycles since reset.
  int          m_pos = 0;
  logic [15:0] m_disp_v = '0, m_pend_v = '0;
  logic [3:0]  m_disp_d = '0, m_pend_d = '0;
  bit          m_pv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit l, input logic [15:0] v,
                            input logic [3:0] d, input bit lz, output exp_t x);
    int slot, c, hi_nz, hi_dp;
    logic [3:0] code;
    logic [6:0] g;
    logic       pdp, blank;
    logic [3:0] an_h;
    if (!r) begin
      x = '{seg_a: 7'h00, dp_a: 1'b0, an_a: 4'hF, fd: 1'b0,
            seg_b: 7'h7F, dp_b: 1'b1, an_b: 4'hF};
      m_pos = 0; m_disp_v = '0; m_disp_d = '0; m_pend_v = '0; m_pend_d = '0; m_pv = 0;
      return;
    end
    slot = (m_pos / R) % N;
    c    = m_pos % R;
    code = 4'((m_disp_v >> (4 * slot)) & 16'hF);
    hi_nz = -1;
    hi_dp = -1;
    for (int i = 0; i < N; i++) begin
      if (((m_disp_v >> (4 * i)) & 16'hF) != 0) hi_nz = i;
      if (m_disp_d[i]) hi_dp = i;
    end
    blank = lz && (slot > 0) && (slot > hi_nz) && (slot >= hi_dp);
    pdp   = blank ? 1'b0 : m_disp_d[slot];
    an_h  = (e && c >= BL) ? 4'(1 << slot) : 4'h0;
    g     = blank ? 7'h00 : gly[code];
    x.seg_a = g;
    x.dp_a  = pdp;
    x.an_a  = ~an_h;
    x.fd    = e && (m_pos == FR - 1);
    x.seg_b = ~((blank || code > 9) ? 7'h00 : gly[code]);
    x.dp_b  = ~pdp;
    x.an_b  = ~an_h;
    if (e && m_pos == FR - 1) begin
      if (l) begin m_disp_v = v; m_disp_d = d; end
      else if (m_pv) begin m_disp_v = m_pend_v; m_disp_d = m_pend_d; end
      m_pv = 0;
    end else if (l) begin
      m_pend_v = v; m_pend_d = d; m_pv = 1;
    end
    if (e) m_pos = (m_pos + 1) % FR;
  endtask

  // Drive one cycle of stimulus (called at a negedge), queue the expected
  // outputs for the coming posedge, then advance to the next negedge.
  task automatic step(input bit r, input bit e, input bit l, input logic [15:0] v,
                      input logic [3:0] d, input bit lz);
    exp_t x;
    bus_a.en = e; bus_a.load = l; bus_a.value = v; bus_a.dp_in = d; bus_a.lz_blank = lz;
    bus_b.en = e; bus_b.load = l; bus_b.value = v; bus_b.dp_in = d; bus_b.lz_blank = lz;
    model_step(r, e, l, v, d, lz, x);
    sb.push_back(x);
    if (!r && rst_n) begin
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_seg_a", 32'(bus_a.seg), 32'h00);
      chk("async_rst_dp_a", 32'(bus_a.dp), 32'h0);
      chk("async_rst_an_a", 32'(bus_a.an), 32'hF);
      chk("async_rst_fd_a", 32'(bus_a.frame_done), 32'h0);
      chk("async_rst_seg_b", 32'(bus_b.seg), 32'h7F);
      chk("async_rst_dp_b", 32'(bus_b.dp), 32'h1);
      chk("async_rst_an_b", 32'(bus_b.an), 32'hF);
    end else begin
      rst_n = r;
    end
    @(negedge clk);
  endtask

  // Monitor: outputs are registered, so compare once per cycle on the
  // falling edge against the oldest queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("seg_a", 32'(bus_a.seg), 32'(x.seg_a));
        chk("dp_a", 32'(bus_a.dp), 32'(x.dp_a));
        chk("an_a", 32'(bus_a.an), 32'(x.an_a));
        chk("frame_done_a", 32'(bus_a.frame_done), 32'(x.fd));
        chk("seg_b", 32'(bus_b.seg), 32'(x.seg_b));
        chk("dp_b", 32'(bus_b.dp), 32'(x.dp_b));
        chk("an_b", 32'(bus_b.an), 32'(x.an_b));
        chk("frame_done_b", 32'(bus_b.frame_done), 32'(x.fd));
      end
    end
  end

  initial begin
    logic [15:0] v;
    logic [3:0]  d;
    bit          e, l, lz;
    int          guard;

    repeat (3) step(0, 0, 0, 16'h0, 4'h0, 0);

    // Basic scan of 0x1234 with dead time.
    step(1, 1, 1, 16'h1234, 4'b0000, 0);
    repeat (40) step(1, 1, 0, 16'h0, 4'h0, 0);

    // Leading-zero suppression with a hex digit.
    step(1, 1, 1, 16'h00A5, 4'b0000, 1);
    repeat (36) step(1, 1, 0, 16'h0, 4'h0, 1);

    // Two loads inside one frame: the last one wins.
    repeat (5) step(1, 1, 0, 16'h0, 4'h0, 0);
    step(1, 1, 1, 16'h1111, 4'b0000, 0);
    step(1, 1, 0, 16'h0, 4'h0, 0);
    step(1, 1, 1, 16'h2222, 4'b0101, 0);
    repeat (40) step(1, 1, 0, 16'h0, 4'h0, 0);

    // Load on the wrap cycle goes straight into the new frame.
    guard = 0;
    while (m_pos != FR - 1 && guard < FR) begin
      step(1, 1, 0, 16'h0, 4'h0, 1);
      guard++;
    end
    step(1, 1, 1, 16'h8070, 4'b0010, 1);
    repeat (20) step(1, 1, 0, 16'h0, 4'h0, 1);

    // Freeze mid-slot for 10 cycles, with a load arriving while frozen.
    guard = 0;
    while (m_pos % R != 2 && guard < R) begin
      step(1, 1, 0, 16'h0, 4'h0, 0);
      guard++;
    end
    repeat (4) step(1, 0, 0, 16'h0, 4'h0, 0);
    step(1, 0, 1, 16'h0C09, 4'b1000, 0);
    repeat (5) step(1, 0, 0, 16'h0, 4'h0, 0);
    repeat (36) step(1, 1, 0, 16'h0, 4'h0, 0);

    // Randomized traffic.
    repeat (600) begin
      for (int k = 0; k < 4; k++) begin
        v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      d  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      e  = ($urandom_range(0, 7) != 0);
      l  = ($urandom_range(0, 7) == 0);
      lz = ($urandom_range(0, 3) != 0);
      step(1, e, l, v, d, lz);
    end

    // Asynchronous reset mid-scan with a pending load outstanding.
    step(1, 1, 1, 16'h9999, 4'b1111, 0);
    repeat (3) step(1, 1, 0, 16'h0, 4'h0, 0);
    step(0, 1, 0, 16'h0, 4'h0, 0);
    step(0, 1, 0, 16'h0, 4'h0, 0);
    repeat (40) step(1, 1, 0, 16'h0, 4'h0, 0);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
